// File: rtl/kitt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kitt_pkg
//  Description : Definitions shared by the KITT scanner and its monitor:
//                LED count, the all-off pattern, the monitor FSM state
//                encoding and the error codes it reports.
//  Revision    : 1.0 - initial release
// ============================================================================
package kitt_pkg;

    // Scanner geometry. LEDs are active-low, so all-off is all-ones.
    localparam int          N_LED   = 8;
    localparam logic [7:0]  LED_OFF = 8'hFF;

    // Error codes; only the first error after a clear is retained.
    localparam logic [1:0]  ERR_NONE   = 2'b00;
    localparam logic [1:0]  ERR_ONEHOT = 2'b01;
    localparam logic [1:0]  ERR_MOVE   = 2'b10;

    // Monitor FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQ     = 2'd1,
        LOCK_UP = 2'd2,
        LOCK_DN = 2'd3
    } state_t;

endpackage : kitt_pkg
`default_nettype wire

// File: rtl/kitt_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : kitt_onehot_dec
//  Description : Combinational decoder for an active-low one-hot LED
//                pattern. Reports whether exactly one LED is lit and, if
//                so, its index.
//  Ports       : i_led_n  [N_LED-1:0]  pattern, active-low
//                o_valid               1 when exactly one bit is 0
//                o_pos    [2:0]        index of the lit LED (bit 0 = LED0);
//                                      don't-care when o_valid is 0
//  Revision    : 1.0 - initial release
// ============================================================================
module kitt_onehot_dec
    import kitt_pkg::*;
(
    input  logic [N_LED-1:0] i_led_n,
    output logic             o_valid,
    output logic [2:0]       o_pos
);

    logic [3:0] w_lit_cnt;

    // Count lit LEDs; the highest lit index wins the position, which only
    // matters when the pattern is already invalid.
    always_comb begin
        w_lit_cnt = 4'd0;
        o_pos     = 3'd0;
        for (int i = 0; i < N_LED; i++) begin
            if (!i_led_n[i]) begin
                w_lit_cnt = w_lit_cnt + 4'd1;
                o_pos     = 3'(i);
            end
        end
        o_valid = (w_lit_cnt == 4'd1);
    end

endmodule : kitt_onehot_dec
`default_nettype wire

// File: rtl/kitt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : kitt_monitor
//  Description : Observer for the KITT LED scanner. Samples the active-low
//                one-hot scan pattern, tracks lit position and sweep
//                direction, measures how long each pattern was held and
//                flags malformed patterns or illegal moves.
//  Parameters  : PERIOD_W  width of hold counter / period output (saturating)
//  Macro       : KITT_MON_SYNC_EN - when defined, a 2-flop synchronizer
//                precedes the sample register (4-clock latency, for
//                asynchronous board pins); otherwise 2-clock latency.
//  Ports       : ck        system clock, rising edge
//                r         asynchronous active-low reset
//                led_in    [7:0] scanner pattern, active-low
//                err_clr   synchronous pulse, clears err / err_code
//                pos       [2:0] lit LED index
//                dir       0 = up, 1 = down
//                locked    1 while in LOCK_UP or LOCK_DN
//                step      one-cycle pulse per legal step
//                period    [PERIOD_W-1:0] hold time of the pattern just left
//                err       sticky error flag
//                err_code  [1:0] first error since clear
//  Revision    : 1.0 - initial release
// ============================================================================
module kitt_monitor
    import kitt_pkg::*;
#(
    parameter int PERIOD_W = 22
) (
    input  logic                ck,
    input  logic                r,
    input  logic [N_LED-1:0]    led_in,
    input  logic                err_clr,
    output logic [2:0]          pos,
    output logic                dir,
    output logic                locked,
    output logic                step,
    output logic [PERIOD_W-1:0] period,
    output logic                err,
    output logic [1:0]          err_code
);

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic [N_LED-1:0] w_s_in;
    logic [N_LED-1:0] r_s;
    logic [N_LED-1:0] r_s_prev;

`ifdef KITT_MON_SYNC_EN
    logic [N_LED-1:0] r_sync1;
    logic [N_LED-1:0] r_sync2;

    // Reset to all-off so that leaving reset is not seen as a change.
    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_sync1 <= LED_OFF;
            r_sync2 <= LED_OFF;
        end else begin
            r_sync1 <= led_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s_in = r_sync2;
`else
    assign w_s_in = led_in;
`endif

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_s      <= LED_OFF;
            r_s_prev <= LED_OFF;
        end else begin
            r_s      <= w_s_in;
            r_s_prev <= r_s;
        end
    end

    logic w_change;
    assign w_change = (r_s != r_s_prev);

    logic       w_valid;
    logic [2:0] w_new_pos;

    kitt_onehot_dec u_dec (
        .i_led_n (r_s),
        .o_valid (w_valid),
        .o_pos   (w_new_pos)
    );

    // ------------------------------------------------------------------
    // Hold counter: counts clocks the current sample has been stable.
    // Set to 1 on the change itself so a pattern held N clocks reads N.
    // ------------------------------------------------------------------
    logic [PERIOD_W-1:0] r_hold;

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_hold <= '0;
        end else if (w_change) begin
            r_hold <= PERIOD_W'(1);
        end else if (r_hold != '1) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_pos;
    logic       r_dir;

    logic       w_step_ev;
    logic       w_load_pos;
    logic       w_dir_nxt;
    logic       w_err_ev;
    logic [1:0] w_err_kind;
    logic       w_up_ok;
    logic       w_dn_ok;
    logic       w_locked;

    // Neighbour tests guarded at the ends so the 3-bit index never wraps.
    assign w_up_ok = (r_pos != 3'd7) && (w_new_pos == r_pos + 3'd1);
    assign w_dn_ok = (r_pos != 3'd0) && (w_new_pos == r_pos - 3'd1);

    // State register
    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and event classification
    always_comb begin
        w_state_nxt = r_state;
        w_step_ev   = 1'b0;
        w_load_pos  = 1'b0;
        w_dir_nxt   = r_dir;
        w_err_ev    = 1'b0;
        w_err_kind  = ERR_NONE;

        case (r_state)
            SEARCH: begin
                // Garbage is tolerated here; the scanner may be starting up.
                if (w_valid) begin
                    w_load_pos  = 1'b1;
                    w_state_nxt = ACQ;
                end
            end

            ACQ: begin
                if (w_change) begin
                    if (!w_valid) begin
                        w_err_ev   = 1'b1;
                        w_err_kind = ERR_ONEHOT;
                    end else if (w_up_ok) begin
                        w_step_ev   = 1'b1;
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = LOCK_UP;
                    end else if (w_dn_ok) begin
                        w_step_ev   = 1'b1;
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = LOCK_DN;
                    end else begin
                        w_err_ev   = 1'b1;
                        w_err_kind = ERR_MOVE;
                    end
                end
            end

            LOCK_UP: begin
                if (w_change) begin
                    if (!w_valid) begin
                        w_err_ev   = 1'b1;
                        w_err_kind = ERR_ONEHOT;
                    end else if (w_up_ok) begin
                        w_step_ev = 1'b1;
                    end else if ((r_pos == 3'd7) && w_dn_ok) begin
                        // Reversal is only legal at the top end.
                        w_step_ev   = 1'b1;
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = LOCK_DN;
                    end else begin
                        w_err_ev   = 1'b1;
                        w_err_kind = ERR_MOVE;
                    end
                end
            end

            LOCK_DN: begin
                if (w_change) begin
                    if (!w_valid) begin
                        w_err_ev   = 1'b1;
                        w_err_kind = ERR_ONEHOT;
                    end else if (w_dn_ok) begin
                        w_step_ev = 1'b1;
                    end else if ((r_pos == 3'd0) && w_up_ok) begin
                        w_step_ev   = 1'b1;
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = LOCK_UP;
                    end else begin
                        w_err_ev   = 1'b1;
                        w_err_kind = ERR_MOVE;
                    end
                end
            end

            default: begin
                w_state_nxt = SEARCH;
            end
        endcase

        if (w_err_ev) begin
            w_state_nxt = SEARCH;
        end
    end

    // State-decoded outputs
    always_comb begin
        w_locked = 1'b0;
        if ((r_state == LOCK_UP) || (r_state == LOCK_DN)) begin
            w_locked = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered reporting outputs. pos/dir are left untouched on error
    // so the last good position is visible alongside the flag.
    // ------------------------------------------------------------------
    logic                r_step;
    logic [PERIOD_W-1:0] r_period;
    logic                r_err;
    logic [1:0]          r_err_code;

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_pos      <= 3'd0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_period   <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_step <= w_step_ev;

            if (w_load_pos || w_step_ev) begin
                r_pos <= w_new_pos;
            end

            if (w_step_ev) begin
                r_dir    <= w_dir_nxt;
                r_period <= r_hold;
            end

            // A new error beats a simultaneous clear and takes its code.
            if (w_err_ev) begin
                r_err <= 1'b1;
                if ((r_err_code == ERR_NONE) || err_clr) begin
                    r_err_code <= w_err_kind;
                end
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end
        end
    end

    assign pos      = r_pos;
    assign dir      = r_dir;
    assign locked   = w_locked;
    assign step     = r_step;
    assign period   = r_period;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule : kitt_monitor
`default_nettype wire

// File: tb/tb_kitt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kitt_monitor
//  Description : Self-checking bench for kitt_monitor. Stimulus pushes the
//                expected step and error events into queues; a monitor
//                pops and compares whenever step pulses or err rises.
//                Runs with a narrow PERIOD_W so saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kitt_monitor;

    localparam int PW = 8;
`ifdef KITT_MON_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          ck;
    logic          r;
    logic [7:0]    led_in;
    logic          err_clr;
    logic [2:0]    pos;
    logic          dir;
    logic          locked;
    logic          step;
    logic [PW-1:0] period;
    logic          err;
    logic [1:0]    err_code;

    kitt_monitor #(.PERIOD_W(PW)) dut (
        .ck       (ck),
        .r        (r),
        .led_in   (led_in),
        .err_clr  (err_clr),
        .pos      (pos),
        .dir      (dir),
        .locked   (locked),
        .step     (step),
        .period   (period),
        .err      (err),
        .err_code (err_code)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct packed {
        logic [2:0]    pos;
        logic          dir;
        logic [PW-1:0] period;
    } step_t;

    typedef struct packed {
        logic [1:0] code;
        logic [2:0] pos;
    } err_t;

    step_t step_q[$];
    err_t  err_q[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] led(input int p);
        logic [7:0] v;
        v    = 8'hFF;
        v[p] = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_flags"}, {20'd0, pos, dir, locked, step, err, err_code}, 32'd0);
        chk({name, "_period"}, {24'd0, period}, 32'd0);
    endtask

    task automatic exp_step(input int p, input bit d, input int per);
        step_t e;
        e.pos    = 3'(p);
        e.dir    = d;
        e.period = PW'(per);
        step_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] code, input int p);
        err_t e;
        e.code = code;
        e.pos  = 3'(p);
        err_q.push_back(e);
    endtask

    // Present a pattern for 'hold' clock edges; returns at posedge+1.
    task automatic apply(input logic [7:0] pat, input int hold, input bit clr = 1'b0);
        led_in  = pat;
        err_clr = clr;
        repeat (hold) begin
            @(posedge ck);
            #1;
            err_clr = 1'b0;
        end
    endtask

    // Monitor: compares DUT events against the queued expectations.
    initial begin
        bit    err_prev;
        step_t es;
        err_t  ee;
        err_prev = 1'b0;
        forever begin
            @(negedge ck);
            if (step === 1'b1) begin
                n_checks++;
                if (step_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_step: got step at pos=%0d, required no step", pos);
                end else begin
                    es = step_q.pop_front();
                    if (pos !== es.pos || dir !== es.dir || period !== es.period || locked !== 1'b1) begin
                        n_errors++;
                        $display("FAIL step: got pos=%0d dir=%0d period=%0d locked=%0d, required pos=%0d dir=%0d period=%0d locked=1",
                                 pos, dir, period, locked, es.pos, es.dir, es.period);
                    end
                end
            end
            if (err === 1'b1 && !err_prev) begin
                n_checks++;
                if (err_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_err: got err code=%0b pos=%0d, required no error", err_code, pos);
                end else begin
                    ee = err_q.pop_front();
                    if (err_code !== ee.code || pos !== ee.pos || locked !== 1'b0) begin
                        n_errors++;
                        $display("FAIL err_event: got code=%0b pos=%0d locked=%0d, required code=%0b pos=%0d locked=0",
                                 err_code, pos, locked, ee.code, ee.pos);
                    end
                end
            end
            err_prev = (err === 1'b1);
        end
    end

    // Sweep 0->7->0->1, then on up to 3 while locked upward.
    int seq [17] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3};

    initial begin
        int  prev;
        bit  d;
        int  lat;
        bit  found;

        r       = 1'b0;
        led_in  = 8'hFF;
        err_clr = 1'b0;

        @(posedge ck);
        #1;
        chk_reset("reset_init");
        @(posedge ck);
        #1 r = 1'b1;
        @(posedge ck);
        #1;

        // All-off from reset is not an error; one lit LED enters ACQ.
        apply(8'hFF, 20);
        chk("ff_idle", {29'd0, err, locked, err_code[0]}, 32'd0);
        apply(led(0), 16);
        chk("acq_pos0", {27'd0, pos, locked, err}, 32'd0);

        prev = 0;
        foreach (seq[i]) begin
            d = (seq[i] < prev);
            exp_step(seq[i], d, 16);
            apply(led(seq[i]), 16);
            prev = seq[i];
        end
        chk("sweep_locked_noerr", {29'd0, locked, err, dir}, 32'b100);

        // Jump 3 -> 5 while locked upward.
        exp_err(2'b10, 3);
        apply(led(5), 16);
        chk("jump_flags", {28'd0, err, err_code, locked}, 32'b1100);

        // Clear, then reacquire at 5 and walk down to 3.
        exp_step(4, 1'b1, 16);
        apply(led(4), 16, 1'b1);
        chk("clr_after_jump", {29'd0, err, err_code}, 32'd0);
        exp_step(3, 1'b1, 16);
        apply(led(3), 16);

        // Two LEDs lit while locked downward.
        exp_err(2'b01, 3);
        apply(8'b1110_0111, 16);
        chk("twohot_flags", {29'd0, err, err_code}, 32'b101);

        // Clear, then hold pos 0 long enough to saturate the counter.
        apply(8'hFE, 300, 1'b1);
        chk("clr_after_twohot", {29'd0, err, err_code}, 32'd0);
        exp_step(1, 1'b0, 255);
        apply(led(1), 16);
        exp_step(2, 1'b0, 16);
        apply(led(2), 16);
        exp_step(3, 1'b0, 16);
        apply(led(3), 16);
        exp_step(4, 1'b0, 16);
        apply(led(4), 16);
        exp_step(5, 1'b0, 16);
        apply(led(5), 5);
        chk("pre_reset_pos5", {28'd0, pos, locked}, {28'd0, 3'd5, 1'b1});

        // Asynchronous reset mid-hold, away from any clock edge.
        #1 r = 1'b0;
        #1;
        chk_reset("async_reset");
        repeat (2) @(posedge ck);
        #1;
        chk_reset("reset_held");
        led_in = 8'hFF;
        #1 r = 1'b1;
        @(posedge ck);
        #1;

        apply(8'hFF, 10);
        chk("post_reset_idle", {29'd0, err, locked, step}, 32'd0);
        apply(8'hFE, 16);

        // Input-to-step latency.
        exp_step(1, 1'b0, 16);
        led_in = led(1);
        lat    = 0;
        found  = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(posedge ck);
            #1;
            if (step === 1'b1) begin
                found = 1'b1;
                lat   = i;
            end
        end
        chk("latency", lat, LAT);

        repeat (20) @(posedge ck);
        #1;
        chk("step_q_drained", step_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_kitt_monitor
`default_nettype wire
